// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and helpers for the N-channel registered mux/arbiter.
//   mode_t : grant source select (SEL, PRIO, RR); encoding 3 is reserved and
//            is treated as SEL by the datapath.
//   ch_w() : width of a channel index, never below 1 bit.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    MODE_SEL  = 2'd0,
    MODE_PRIO = 2'd1,
    MODE_RR   = 2'd2
  } mode_t;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// rr_arbiter: rotate-priority arbiter.
//   req     in  N_CH  request vector
//   base    in  CH_W  highest-priority index; search wraps N_CH-1 -> 0
//   gnt     out N_CH  one-hot grant, zero when no request
//   gnt_idx out CH_W  index of the granted request (0 when none)
// With base tied to 0 this degenerates to lowest-index fixed priority.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] base,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx
);

  always_comb begin : arb
    logic            found;
    int              idx;
    logic [CH_W-1:0] w_idx;
    found   = 1'b0;
    idx     = 0;
    w_idx   = '0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(base) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      w_idx = CH_W'(idx);
      if (!found && req[w_idx]) begin
        found        = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel WIDTH-bit mux/arbiter with a one-entry registered
// output stage and valid/ready on both sides.
//   clk, reset     clock; synchronous active-low reset
//   mode           mode_t: SEL / PRIO / RR (3 behaves as SEL)
//   sel            channel index for SEL mode
//   in_valid/in_data/in_ready   per-channel input handshake, data packed
//                               channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_ch/out_ready  registered output handshake
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N_CH  = 4,
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [CH_W-1:0]       sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CH_W-1:0]  r_out_ch;
  logic [CH_W-1:0]  r_rr_ptr;

  logic             w_load;
  logic             w_is_rr;
  logic             w_is_arb;
  logic [CH_W-1:0]  w_base;
  logic [N_CH-1:0]  w_arb_gnt;
  logic [CH_W-1:0]  w_arb_idx;
  logic [N_CH-1:0]  w_sel_gnt;
  logic [N_CH-1:0]  w_grant;
  logic [CH_W-1:0]  w_gidx;
  logic [WIDTH-1:0] w_data;

  assign w_load   = !r_out_valid || out_ready;
  assign w_is_rr  = (mode == MODE_RR);
  assign w_is_arb = (mode == MODE_RR) || (mode == MODE_PRIO);
  // PRIO shares the rotating arbiter with its base pinned to 0.
  assign w_base   = w_is_rr ? r_rr_ptr : '0;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (in_valid),
    .base    (w_base),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx)
  );

  // Out-of-range sel (only possible when N_CH is not a power of two) grants nothing.
  always_comb begin
    w_sel_gnt = '0;
    if (int'(sel) < N_CH && in_valid[sel]) w_sel_gnt[sel] = 1'b1;
  end

  assign w_grant = w_is_arb ? w_arb_gnt : w_sel_gnt;
  assign w_gidx  = w_is_arb ? w_arb_idx : sel;

  // Grant is one-hot, so an AND-OR select is exact and avoids a wide index mux.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_CH; i++)
      w_data = w_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
  end

  // Gated by reset so nothing is handed off while the output stage is being cleared.
  assign in_ready = w_grant & {N_CH{w_load & reset}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (|w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_ch    <= w_gidx;
        if (w_is_rr)
          r_rr_ptr <= (int'(w_gidx) == N_CH-1) ? '0 : w_gidx + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;
  import mux_arb_pkg::*;

  localparam int WIDTH = 64;
  localparam int N_CH  = 4;
  localparam int CH_W  = 2;

  logic                  clk;
  logic                  reset;
  logic [1:0]            mode;
  logic [CH_W-1:0]       sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-picked per-channel words; high bits catch truncated data paths.
  logic [WIDTH-1:0] d [N_CH];

  mux_arb_n #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; mode = MODE_SEL; sel = '0; out_ready = 1'b1;
    in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 64'd0 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL reset cyc%0d: got v=%b d=%h ch=%0d rdy=%b, want v=0 d=0 ch=0 rdy=0000",
                 c, out_valid, out_data, out_ch, in_ready);
      end
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_sel;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mode = MODE_SEL; sel = CH_W'(i); in_valid = 4'b1111;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== d[i] || out_ch !== CH_W'(i)) begin
        n_err++;
        $display("FAIL sel%0d: got v=%b d=%h ch=%0d, want v=1 d=%h ch=%0d",
                 i, out_valid, out_data, out_ch, d[i], i);
      end
      n_cmp++;
      if (in_ready !== (4'b0001 << i)) begin
        n_err++;
        $display("FAIL sel%0d_ready: got %b want %b", i, in_ready, 4'b0001 << i);
      end
    end
    // Selected channel not valid: bubble, data/ch hold last word.
    @(negedge clk); sel = 2'd2; in_valid = 4'b1011;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== d[3] || out_ch !== 2'd3 || in_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL sel_invalid: got v=%b d=%h ch=%0d rdy=%b, want v=0 d=%h ch=3 rdy=0000",
               out_valid, out_data, out_ch, in_ready, d[3]);
    end
    // Reserved mode 3 behaves as SEL.
    @(negedge clk); mode = 2'd3; sel = 2'd1; in_valid = 4'b1111;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== d[1] || out_ch !== 2'd1) begin
      n_err++;
      $display("FAIL mode3: got v=%b d=%h ch=%0d, want v=1 d=%h ch=1",
               out_valid, out_data, out_ch, d[1]);
    end
  endtask

  task automatic test_prio;
    @(negedge clk); mode = MODE_PRIO; sel = 2'd3; in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== d[1] || in_ready !== 4'b0010) begin
        n_err++;
        $display("FAIL prio%0d: got v=%b ch=%0d d=%h rdy=%b, want v=1 ch=1 d=%h rdy=0010",
                 c, out_valid, out_ch, out_data, in_ready, d[1]);
      end
    end
    @(negedge clk); in_valid = 4'b1000;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== d[3] || in_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL prio_drop: got v=%b ch=%0d d=%h rdy=%b, want v=1 ch=3 d=%h rdy=1000",
               out_valid, out_ch, out_data, in_ready, d[3]);
    end
  endtask

  task automatic test_rr;
    logic [CH_W-1:0] exp_ch [6];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    @(negedge clk); mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch[c] || out_data !== d[exp_ch[c]]) begin
        n_err++;
        $display("FAIL rr%0d: got v=%b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                 c, out_valid, out_ch, out_data, exp_ch[c], d[exp_ch[c]]);
      end
      // Pointer now sits one past the winner, so that channel is offered next.
      n_cmp++;
      if (in_ready !== (4'b0001 << ((exp_ch[c] + 1) % 4))) begin
        n_err++;
        $display("FAIL rr%0d_ready: got %b want %b", c, in_ready, 4'b0001 << ((exp_ch[c] + 1) % 4));
      end
    end
  endtask

  task automatic test_stall;
    // Pointer is at 2 after the RR test.
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== d[2]) begin
      n_err++;
      $display("FAIL stall_first: got v=%b ch=%0d d=%h, want v=1 ch=2 d=%h",
               out_valid, out_ch, out_data, d[2]);
    end
    @(negedge clk); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== d[2] || in_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b ch=%0d d=%h rdy=%b, want v=1 ch=2 d=%h rdy=0000",
                 c, out_valid, out_ch, out_data, in_ready, d[2]);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== d[3] || in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL stall_release: got v=%b ch=%0d d=%h rdy=%b, want v=1 ch=3 d=%h rdy=0001",
               out_valid, out_ch, out_data, in_ready, d[3]);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== d[0]) begin
      n_err++;
      $display("FAIL stall_next: got v=%b ch=%0d d=%h, want v=1 ch=0 d=%h",
               out_valid, out_ch, out_data, d[0]);
    end
  endtask

  task automatic test_midstall_reset;
    // Pointer is at 1; hold ch0 in the output stage, then reset.
    @(negedge clk); out_ready = 1'b0;
    tick();
    @(negedge clk); reset = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset: got v=%b d=%h ch=%0d rdy=%b, want v=0 d=0 ch=0 rdy=0000",
               out_valid, out_data, out_ch, in_ready);
    end
    @(negedge clk); reset = 1'b1; out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== d[0]) begin
      n_err++;
      $display("FAIL midreset_restart: got v=%b ch=%0d d=%h, want v=1 ch=0 d=%h",
               out_valid, out_ch, out_data, d[0]);
    end
    // Pointer at 1, only ch0 valid: search must wrap 3 -> 0.
    @(negedge clk); in_valid = 4'b0001;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== d[0] || in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rr_wrap: got v=%b ch=%0d d=%h rdy=%b, want v=1 ch=0 d=%h rdy=0001",
               out_valid, out_ch, out_data, in_ready, d[0]);
    end
  endtask

  initial begin
    d[0] = 64'hC0DE_0000_0000_0001;
    d[1] = 64'hC0DE_1000_0000_0002;
    d[2] = 64'hC0DE_2000_0000_0003;
    d[3] = 64'hC0DE_3000_0000_0004;
    in_data = {d[3], d[2], d[1], d[0]};
    test_reset();
    test_sel();
    test_prio();
    test_rr();
    test_stall();
    test_midstall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
